// File: rtl/wb_regfile_if.sv
// Bundle of the W-stage writeback inputs, decode read ports and writeback result
// shared by the pipeline (master) and the writeback register file (slave).
`timescale 1ns/1ps
interface wb_regfile_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic [XLEN-1:0] ALU_resultW;
  logic [XLEN-1:0] read_dataW;
  logic [XLEN-1:0] pcplus4W;
  logic [AW-1:0]   rdW;
  logic            reg_writeW;
  logic [1:0]      result_srcW;
  logic [AW-1:0]   rs1D;
  logic [AW-1:0]   rs2D;
  logic [XLEN-1:0] rd1D;
  logic [XLEN-1:0] rd2D;
  logic [XLEN-1:0] resultW;
  logic            wb_activeW;

  modport master (
    output ALU_resultW, read_dataW, pcplus4W, rdW, reg_writeW, result_srcW, rs1D, rs2D,
    input  rd1D, rd2D, resultW, wb_activeW
  );

  modport slave (
    input  ALU_resultW, read_dataW, pcplus4W, rdW, reg_writeW, result_srcW, rs1D, rs2D,
    output rd1D, rd2D, resultW, wb_activeW
  );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage: selects the W-stage result, commits it to a 32-entry register
// file and serves two decode read ports with same-cycle write-to-read bypass.
`timescale 1ns/1ps
module wb_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  wb_regfile_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [XLEN-1:0] result_s;
  logic            wb_active_s;
  logic [XLEN-1:0] rd1_s;
  logic [XLEN-1:0] rd2_s;

  // Writeback result select; the reserved encoding falls back to the ALU result.
  always_comb begin
    case (bus.result_srcW)
      2'b00:   result_s = bus.ALU_resultW;
      2'b01:   result_s = bus.read_dataW;
      2'b10:   result_s = bus.pcplus4W;
      default: result_s = bus.ALU_resultW;
    endcase
  end

  // Commit qualifier; reset also masks it so the bypass path goes quiet in reset.
  always_comb begin
    wb_active_s = rst_n & bus.reg_writeW & (bus.rdW != {AW{1'b0}});
  end

  // Next register-file state; x0 is pinned to zero.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = (wb_active_s && (bus.rdW == AW'(i))) ? result_s : regs_q[i];
    end
    regs_d[0] = {XLEN{1'b0}};
  end

  // Register file storage with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= {XLEN{1'b0}};
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read port 1 with bypass from the value being written back this cycle.
  always_comb begin
    if (!rst_n || (bus.rs1D == {AW{1'b0}})) begin
      rd1_s = {XLEN{1'b0}};
    end else if (wb_active_s && (bus.rdW == bus.rs1D)) begin
      rd1_s = result_s;
    end else begin
      rd1_s = regs_q[bus.rs1D];
    end
  end

  // Read port 2, same rules as port 1.
  always_comb begin
    if (!rst_n || (bus.rs2D == {AW{1'b0}})) begin
      rd2_s = {XLEN{1'b0}};
    end else if (wb_active_s && (bus.rdW == bus.rs2D)) begin
      rd2_s = result_s;
    end else begin
      rd2_s = regs_q[bus.rs2D];
    end
  end

  assign bus.resultW    = result_s;
  assign bus.wb_activeW = wb_active_s;
  assign bus.rd1D       = rd1_s;
  assign bus.rd2D       = rd2_s;
endmodule
